// File: rtl/dram_responder.sv
// Memory-side responder for the byte-serial DRAM interface: fixed-latency burst reads/writes.
// Optional periodic refresh stall is enabled by defining DRAM_REFRESH_EN.
module dram_responder #(
    parameter int MEM_BYTES      = 4096,
    parameter int LATENCY        = 4,
    parameter int BURST_LEN      = 4,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dram_signal,
    input  logic [31:0] dram_addr_rd,
    input  logic [31:0] dram_addr_wr,
    input  logic [7:0]  dram_write_data,
    output logic        dram_ready,
    output logic [7:0]  dram_result
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef DRAM_REFRESH_EN
    typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE, REFRESH} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE} state_t;
`endif

    state_t          state, state_next;
    logic            is_wr;
    logic [AW-1:0]   base;
    logic [BW-1:0]   beat;
    logic [LW-1:0]   lat_cnt;
    logic [7:0]      mem [MEM_BYTES];

    logic            req_rd, req_wr, last_lat, last_beat;
    logic [AW-1:0]   rd_addr, wr_addr;

    assign req_rd    = (dram_signal == 2'b01);
    assign req_wr    = (dram_signal == 2'b10);
    assign last_lat  = (lat_cnt == LW'(LATENCY - 1));
    assign last_beat = (beat == BW'(BURST_LEN - 1));
    assign wr_addr   = base + AW'(beat);
    // Prefetch address for the beat presented next cycle: beat 0 from WAIT, beat+1 during a burst.
    assign rd_addr   = (state == WAIT) ? base : base + AW'(beat) + AW'(1);

`ifdef DRAM_REFRESH_EN
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RW-1:0] ref_timer;
    logic [CW-1:0] ref_len;
    logic          refresh_pending, ref_tick, ref_last;

    assign ref_tick = (ref_timer == RW'(REFRESH_PERIOD - 1));
    assign ref_last = (ref_len == CW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_timer       <= '0;
            ref_len         <= '0;
            refresh_pending <= 1'b0;
        end else begin
            ref_timer <= ref_tick ? '0 : ref_timer + RW'(1);
            ref_len   <= (state == REFRESH) ? ref_len + CW'(1) : '0;
            if (ref_tick)
                refresh_pending <= 1'b1;
            else if (state == REFRESH && ref_last)
                refresh_pending <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (refresh_pending)
                    state_next = REFRESH;
                else
`endif
                if (req_rd || req_wr)
                    state_next = WAIT;
            end
            WAIT:     if (last_lat) state_next = is_wr ? WR_BURST : RD_BURST;
            RD_BURST: if (last_beat) state_next = DONE;
            WR_BURST: if (last_beat) state_next = DONE;
            DONE:     state_next = IDLE;
`ifdef DRAM_REFRESH_EN
            REFRESH:  if (ref_last) state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr       <= 1'b0;
            base        <= '0;
            beat        <= '0;
            lat_cnt     <= '0;
            dram_ready  <= 1'b0;
            dram_result <= '0;
        end else begin
            dram_ready  <= (state_next == RD_BURST) || (state_next == WR_BURST);
            dram_result <= (state_next == RD_BURST) ? mem[rd_addr] : '0;
            case (state)
                IDLE: if (state_next == WAIT) begin
                    is_wr   <= req_wr;
                    base    <= req_wr ? dram_addr_wr[AW-1:0] : dram_addr_rd[AW-1:0];
                    beat    <= '0;
                    lat_cnt <= '0;
                end
                WAIT:     if (!last_lat) lat_cnt <= lat_cnt + LW'(1);
                RD_BURST: if (!last_beat) beat <= beat + BW'(1);
                WR_BURST: if (!last_beat) beat <= beat + BW'(1);
                default: ;
            endcase
        end
    end

    // Array is never cleared; a reset edge suppresses the in-flight write beat.
    always_ff @(posedge clk) begin
        if (!rst && state == WR_BURST)
            mem[wr_addr] <= dram_write_data;
    end

endmodule

// File: tb/tb_dram_responder.sv
// Directed, table-driven bench for dram_responder at default parameters (refresh disabled).
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dram_signal;
    logic [31:0] dram_addr_rd;
    logic [31:0] dram_addr_wr;
    logic [7:0]  dram_write_data;
    logic        dram_ready;
    logic [7:0]  dram_result;

    int n_checks = 0;
    int n_fail   = 0;

    dram_responder #(
        .MEM_BYTES(4096),
        .LATENCY(4),
        .BURST_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dram_signal(dram_signal),
        .dram_addr_rd(dram_addr_rd),
        .dram_addr_wr(dram_addr_wr),
        .dram_write_data(dram_write_data),
        .dram_ready(dram_ready),
        .dram_result(dram_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;   // byte i of the burst in bits [8*i +: 8]
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request in cycle 0, beats in cycles 5..8, DONE in cycle 9; returns in cycle 10.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input string tag);
        dram_signal     = wr ? 2'b10 : 2'b01;
        dram_addr_rd    = wr ? 32'hDEAD_0F0F : addr;
        dram_addr_wr    = wr ? addr : 32'hBEEF_0A0A;
        dram_write_data = 8'h00;
        check({tag, " ready c0"}, 32'(dram_ready), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) begin
                dram_signal  = 2'b00;
                dram_addr_rd = 32'h0000_0777;
                dram_addr_wr = 32'h0000_0555;
            end
            if (c >= 5 && c <= 8) begin
                check($sformatf("%s ready c%0d", tag, c), 32'(dram_ready), 32'd1);
                if (wr)
                    dram_write_data = data[8*(c-5) +: 8];
                else
                    check($sformatf("%s data beat%0d", tag, c-5), 32'(dram_result),
                          32'(data[8*(c-5) +: 8]));
            end else begin
                check($sformatf("%s ready c%0d", tag, c), 32'(dram_ready), 32'd0);
                check($sformatf("%s result c%0d", tag, c), 32'(dram_result), 32'd0);
            end
        end
        step();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'hDDCC_BBAA};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'hDDCC_BBAA};
        vecs[2] = '{1'b1, 32'h0000_0FFE, 32'h4433_2211};
        vecs[3] = '{1'b0, 32'h0000_0FFE, 32'h4433_2211};
        vecs[4] = '{1'b0, 32'h0000_1FFE, 32'h4433_2211};
        vecs[5] = '{1'b1, 32'h0000_0040, 32'h0807_0605};
        vecs[6] = '{1'b0, 32'h0000_0040, 32'h0807_0605};
        vecs[7] = '{1'b0, 32'hFFFF_F100, 32'hDDCC_BBAA};

        rst = 1'b1;
        dram_signal = 2'b00;
        dram_addr_rd = '0;
        dram_addr_wr = '0;
        dram_write_data = '0;
        step();
        step();
        check("reset ready", 32'(dram_ready), 32'd0);
        check("reset result", 32'(dram_result), 32'd0);
        rst = 1'b0;
        step();
        check("post-reset ready", 32'(dram_ready), 32'd0);

        for (int v = 0; v < 8; v++)
            run_txn(vecs[v].is_wr, vecs[v].addr, vecs[v].data, $sformatf("vec%0d", v));

        // Request held from cycle 0 through 10: second burst starts in cycle 15.
        dram_signal  = 2'b01;
        dram_addr_rd = 32'h0000_0100;
        for (int c = 0; c <= 19; c++) begin
            logic exp_rdy;
            logic [31:0] ref_word;
            if (c > 0) step();
            if (c == 11) dram_signal = 2'b00;
            ref_word = 32'hDDCC_BBAA;
            exp_rdy = (c >= 5 && c <= 8) || (c >= 15 && c <= 18);
            check($sformatf("b2b ready c%0d", c), 32'(dram_ready), 32'(exp_rdy));
            if (exp_rdy)
                check($sformatf("b2b data c%0d", c), 32'(dram_result),
                      32'(ref_word[8*((c >= 15) ? c-15 : c-5) +: 8]));
        end
        step();

        // Reserved code 11 is never accepted.
        dram_signal = 2'b11;
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("rsvd ready c%0d", c), 32'(dram_ready), 32'd0);
        end
        dram_signal = 2'b00;
        step();
        step();

        // Opcode switched to write during WAIT: still completes as a read.
        dram_signal     = 2'b01;
        dram_addr_rd    = 32'h0000_0100;
        dram_addr_wr    = 32'h0000_0100;
        dram_write_data = 8'hFF;
        for (int c = 1; c <= 9; c++) begin
            logic [31:0] ref_word;
            step();
            ref_word = 32'hDDCC_BBAA;
            dram_signal = (c < 9) ? 2'b10 : 2'b00;
            if (c >= 5 && c <= 8) begin
                check($sformatf("switch ready c%0d", c), 32'(dram_ready), 32'd1);
                check($sformatf("switch data c%0d", c), 32'(dram_result),
                      32'(ref_word[8*(c-5) +: 8]));
            end else begin
                check($sformatf("switch ready c%0d", c), 32'(dram_ready), 32'd0);
            end
        end
        step();
        run_txn(1'b0, 32'h0000_0100, 32'hDDCC_BBAA, "switch-unchanged");

        // Reset during beat 2 of a write: bytes 0,1 land, 2,3 keep old contents.
        dram_signal     = 2'b10;
        dram_addr_wr    = 32'h0000_0040;
        dram_addr_rd    = 32'h0000_0000;
        dram_write_data = 8'h00;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) dram_signal = 2'b00;
            if (c == 5) dram_write_data = 8'h01;
            if (c == 6) dram_write_data = 8'h02;
            if (c == 7) begin
                check("rstmid ready beat2", 32'(dram_ready), 32'd1);
                dram_write_data = 8'h03;
                rst = 1'b1;
            end
        end
        step();
        rst = 1'b0;
        check("rstmid ready after rst", 32'(dram_ready), 32'd0);
        check("rstmid result after rst", 32'(dram_result), 32'd0);
        step();
        check("rstmid ready idle", 32'(dram_ready), 32'd0);
        step();
        run_txn(1'b0, 32'h0000_0040, 32'h0807_0201, "rstmid-readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
